// File: rtl/d_mem_arbiter.sv
// Two-port valid/ready arbiter onto the single data memory; bad size/alignment is answered with err and never touches memory.
// Accept->rsp_valid is 2 cycles, one transaction per 3 cycles; ready only in IDLE to the granted port; responses cannot be stalled.
module d_mem_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  logic [BUS_WIDTH-1:0] m0_addr,
  input  logic [BUS_WIDTH-1:0] m0_wr_data,
  input  logic                 m0_wr_en,
  input  logic [1:0]           m0_size,
  input  logic                 m0_sz_ex,
  output logic                 m0_rsp_valid,
  output logic [BUS_WIDTH-1:0] m0_rsp_data,
  output logic                 m0_rsp_err,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  logic [BUS_WIDTH-1:0] m1_addr,
  input  logic [BUS_WIDTH-1:0] m1_wr_data,
  input  logic                 m1_wr_en,
  input  logic [1:0]           m1_size,
  input  logic                 m1_sz_ex,
  output logic                 m1_rsp_valid,
  output logic [BUS_WIDTH-1:0] m1_rsp_data,
  output logic                 m1_rsp_err,
  output logic [BUS_WIDTH-1:0] d_mem_address,
  output logic [BUS_WIDTH-1:0] d_mem_wr_data,
  output logic                 d_mem_wr_en,
  output logic [1:0]           d_mem_size,
  output logic                 d_mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] d_mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wr_data;
    logic                 wr_en;
    logic [1:0]           size;
    logic                 sz_ex;
    logic                 owner;
    logic                 err;
  } req_t;

  state_t               state, state_nxt;
  req_t                 req_q, req_in;
  logic                 rr_last;
  logic                 grant;
  logic                 accept;
  logic [BUS_WIDTH-1:0] rsp_data_q;
  logic                 rsp_err_q;

  // grant = 1 selects port 1; rr_last is the owner of the most recent access
  always_comb begin
    grant = 1'b0;
    if (RR_EN) begin
      if (m0_req_valid && m1_req_valid) grant = ~rr_last;
      else                              grant = m1_req_valid;
    end else begin
      grant = ~m0_req_valid;
    end
  end

  assign m0_req_ready = !rst && (state == IDLE) && m0_req_valid && !grant;
  assign m1_req_ready = !rst && (state == IDLE) && m1_req_valid &&  grant;
  assign accept       = m0_req_ready || m1_req_ready;

  always_comb begin
    req_in       = '0;
    req_in.owner = grant;
    if (grant) begin
      req_in.addr    = m1_addr;
      req_in.wr_data = m1_wr_data;
      req_in.wr_en   = m1_wr_en;
      req_in.size    = m1_size;
      req_in.sz_ex   = m1_sz_ex;
    end else begin
      req_in.addr    = m0_addr;
      req_in.wr_data = m0_wr_data;
      req_in.wr_en   = m0_wr_en;
      req_in.size    = m0_size;
      req_in.sz_ex   = m0_sz_ex;
    end
    req_in.err = (req_in.size == 2'b11) ||
                 ((req_in.size == 2'b01) && req_in.addr[0]) ||
                 ((req_in.size == 2'b10) && (req_in.addr[1:0] != 2'b00));
  end

  always_comb begin
    state_nxt    = state;
    d_mem_wr_en  = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS: begin
        d_mem_wr_en = req_q.wr_en && !req_q.err;
        state_nxt   = RESP;
      end
      RESP: begin
        m0_rsp_valid = !req_q.owner;
        m1_rsp_valid =  req_q.owner;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      rr_last    <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) req_q <= req_in;
      if (state == ACCESS) begin
        rr_last    <= req_q.owner;
        rsp_data_q <= (!req_q.wr_en && !req_q.err) ? d_mem_rd_data : '0;
        rsp_err_q  <= req_q.err;
      end
    end
  end

  // latched request drives memory; it only changes on accept so it holds elsewhere
  assign d_mem_address = req_q.addr;
  assign d_mem_wr_data = req_q.wr_data;
  assign d_mem_size    = req_q.size;
  assign d_mem_sz_ex   = req_q.sz_ex;

  assign m0_rsp_data = rsp_data_q;
  assign m1_rsp_data = rsp_data_q;
  assign m0_rsp_err  = rsp_err_q;
  assign m1_rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Bench for d_mem_arbiter: round-robin instance plus a fixed-priority instance, byte-array memory
// behind each, and a byte-level reference memory that predicts load data, errors and grants.
module tb_d_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req_valid, m0_wr_en, m0_sz_ex, m1_req_valid, m1_wr_en, m1_sz_ex;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wr_data, m1_addr, m1_wr_data;

  logic        m0_req_ready, m0_rsp_valid, m0_rsp_err, m1_req_ready, m1_rsp_valid, m1_rsp_err;
  logic [31:0] m0_rsp_data, m1_rsp_data;
  logic [31:0] d_mem_address, d_mem_wr_data, d_mem_rd_data;
  logic        d_mem_wr_en, d_mem_sz_ex;
  logic [1:0]  d_mem_size;

  logic        fp_m0_req_ready, fp_m0_rsp_valid, fp_m0_rsp_err, fp_m1_req_ready, fp_m1_rsp_valid, fp_m1_rsp_err;
  logic [31:0] fp_m0_rsp_data, fp_m1_rsp_data;
  logic [31:0] fp_d_mem_address, fp_d_mem_wr_data, fp_d_mem_rd_data;
  logic        fp_d_mem_wr_en, fp_d_mem_sz_ex;
  logic [1:0]  fp_d_mem_size;

  d_mem_arbiter #(.BUS_WIDTH(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_wr_en(m0_wr_en), .m0_size(m0_size), .m0_sz_ex(m0_sz_ex),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_wr_en(m1_wr_en), .m1_size(m1_size), .m1_sz_ex(m1_sz_ex),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_rsp_err(m1_rsp_err),
    .d_mem_address(d_mem_address), .d_mem_wr_data(d_mem_wr_data), .d_mem_wr_en(d_mem_wr_en),
    .d_mem_size(d_mem_size), .d_mem_sz_ex(d_mem_sz_ex), .d_mem_rd_data(d_mem_rd_data)
  );

  d_mem_arbiter #(.BUS_WIDTH(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_wr_en(m0_wr_en), .m0_size(m0_size), .m0_sz_ex(m0_sz_ex),
    .m0_rsp_valid(fp_m0_rsp_valid), .m0_rsp_data(fp_m0_rsp_data), .m0_rsp_err(fp_m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_wr_en(m1_wr_en), .m1_size(m1_size), .m1_sz_ex(m1_sz_ex),
    .m1_rsp_valid(fp_m1_rsp_valid), .m1_rsp_data(fp_m1_rsp_data), .m1_rsp_err(fp_m1_rsp_err),
    .d_mem_address(fp_d_mem_address), .d_mem_wr_data(fp_d_mem_wr_data), .d_mem_wr_en(fp_d_mem_wr_en),
    .d_mem_size(fp_d_mem_size), .d_mem_sz_ex(fp_d_mem_sz_ex), .d_mem_rd_data(fp_d_mem_rd_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] dmem    [0:255];
  logic [7:0] ref_mem [0:255];
  int         mem_gen = 0;
  logic       last_own;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] s, input logic x);
    case (s)
      2'b00:   return x ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      2'b01:   return x ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a, input logic [1:0] s, input logic x);
    int b;
    b = int'(a[7:0]);
    return extend({dmem[(b+3)&255], dmem[(b+2)&255], dmem[(b+1)&255], dmem[b]}, s, x);
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] s, input logic x);
    return extend({ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]}, s, x);
  endfunction

  function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  task automatic ref_store(input int a, input logic [31:0] d, input logic [1:0] s);
    for (int k = 0; k < (1 << s); k++) ref_mem[a+k] = d[8*k +: 8];
  endtask

  // memory behind the round-robin instance; the fixed-priority instance only reads it
  always @(posedge clk) begin
    if (d_mem_wr_en) begin
      for (int k = 0; k < (1 << d_mem_size); k++)
        dmem[(int'(d_mem_address[7:0]) + k) & 255] = d_mem_wr_data[8*k +: 8];
      mem_gen++;
    end
  end

  always @(d_mem_address or d_mem_size or d_mem_sz_ex or mem_gen)
    d_mem_rd_data = env_rd(d_mem_address, d_mem_size, d_mem_sz_ex);
  always @(fp_d_mem_address or fp_d_mem_size or fp_d_mem_sz_ex or mem_gen)
    fp_d_mem_rd_data = env_rd(fp_d_mem_address, fp_d_mem_size, fp_d_mem_sz_ex);

  task automatic drive(input logic p, input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [1:0] s, input logic x, input logic v);
    if (p) begin
      m1_addr = a; m1_wr_data = d; m1_wr_en = w; m1_size = s; m1_sz_ex = x; m1_req_valid = v;
    end else begin
      m0_addr = a; m0_wr_data = d; m0_wr_en = w; m0_size = s; m0_sz_ex = x; m0_req_valid = v;
    end
  endtask

  // one lone request on the round-robin instance; reports what was observed, checks nothing
  task automatic txn(input logic p, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input logic [1:0] s, input logic x, output logic acc, output int lat,
                     output logic [31:0] rd, output logic re, output int wrc, output logic oth);
    acc = 1'b0; lat = 0; rd = '0; re = 1'b0; wrc = 0; oth = 1'b0;
    @(negedge clk);
    drive(p, a, d, w, s, x, 1'b1);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (p ? m1_req_ready : m0_req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    if (!acc) begin drive(p, a, d, w, s, x, 1'b0); return; end
    last_own = p;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(p, a, d, w, s, x, 1'b0);
      if (d_mem_wr_en) wrc++;
      if ((p ? m1_rsp_valid : m0_rsp_valid) && lat == 0) begin
        lat = k; rd = p ? m1_rsp_data : m0_rsp_data; re = p ? m1_rsp_err : m0_rsp_err;
      end
      if (p ? m0_rsp_valid : m1_rsp_valid) oth = 1'b1;
    end
  endtask

  task automatic test_reset;
    drive(0, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    drive(1, 32'h8, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_chk++; if (m0_req_ready !== 1'b0) $display("FAIL rst_rdy0 got=%b want=0", m0_req_ready); else n_pass++;
    n_chk++; if (m1_req_ready !== 1'b0) $display("FAIL rst_rdy1 got=%b want=0", m1_req_ready); else n_pass++;
    n_chk++; if (fp_m0_req_ready !== 1'b0) $display("FAIL rst_fp_rdy0 got=%b want=0", fp_m0_req_ready); else n_pass++;
    n_chk++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) $display("FAIL rst_rspv got=%b want=00", {m0_rsp_valid, m1_rsp_valid}); else n_pass++;
    n_chk++; if (d_mem_wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b want=0", d_mem_wr_en); else n_pass++;
    n_chk++; if (d_mem_address !== 32'h0) $display("FAIL rst_addr got=%h want=0", d_mem_address); else n_pass++;
    n_chk++; if ({m0_rsp_data, m0_rsp_err} !== 33'h0) $display("FAIL rst_rsp got=%h/%b want=0/0", m0_rsp_data, m0_rsp_err); else n_pass++;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_own = 1'b0;
  endtask

  task automatic test_store_load;
    logic acc, re, oth; int lat, wrc; logic [31:0] rd;
    txn(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    ref_store(32'h10, 32'hDEADBEEF, 2'd2);
    n_chk++; if (acc !== 1'b1) $display("FAIL st_acc got=%b want=1", acc); else n_pass++;
    n_chk++; if (wrc != 1) $display("FAIL st_wr_cycles got=%0d want=1", wrc); else n_pass++;
    n_chk++; if ({re, rd} !== 33'h0) $display("FAIL st_rsp got=%b/%h want=0/0", re, rd); else n_pass++;
    txn(0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if (lat != 2) $display("FAIL ld_latency got=%0d want=2", lat); else n_pass++;
    n_chk++; if (rd !== ref_load(32'h10, 2'd2, 1'b0)) $display("FAIL ld_data got=%h want=%h", rd, ref_load(32'h10, 2'd2, 1'b0)); else n_pass++;
    n_chk++; if ({re, oth} !== 2'b00 || wrc != 0) $display("FAIL ld_flags got=err%b oth%b wr%0d want=0/0/0", re, oth, wrc); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic acc, re, oth, g, gp; int lat, wrc, grants; logic [31:0] rd, a0, a1;
    logic q_p[$]; logic [31:0] q_d[$];
    logic chg0, chg1;
    txn(1, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if (acc !== 1'b1) $display("FAIL rr_prime_acc got=%b want=1", acc); else n_pass++;
    a0 = 32'($urandom_range(0, 15)) << 2; a1 = 32'($urandom_range(0, 15)) << 2;
    drive(0, a0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    drive(1, a1, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    grants = 0; chg0 = 1'b0; chg1 = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      #1;
      if (m0_rsp_valid || m1_rsp_valid) begin
        n_chk++;
        gp = m1_rsp_valid;
        if (q_p.size() == 0) $display("FAIL rr_rsp unexpected pulse got=%b%b want=none", m1_rsp_valid, m0_rsp_valid);
        else if ((m0_rsp_valid && m1_rsp_valid) || gp !== q_p[0] || (gp ? m1_rsp_data : m0_rsp_data) !== q_d[0])
          $display("FAIL rr_rsp got=port%0d data=%h want=port%0d data=%h", gp, gp ? m1_rsp_data : m0_rsp_data, q_p[0], q_d[0]);
        else n_pass++;
        if (q_p.size() != 0) begin void'(q_p.pop_front()); void'(q_d.pop_front()); end
      end
      if (m0_req_ready || m1_req_ready) begin
        g = m1_req_ready;
        n_chk++;
        if ((m0_req_ready && m1_req_ready) || g !== ~last_own) $display("FAIL rr_grant%0d got=%b%b want=port%0d", grants, m1_req_ready, m0_req_ready, ~last_own);
        else n_pass++;
        q_p.push_back(g); q_d.push_back(ref_load(int'(g ? a1 : a0), 2'd2, 1'b0));
        last_own = g; grants++;
        if (g) chg1 = 1'b1; else chg0 = 1'b1;
      end
      if (grants == 6 && q_p.size() == 0) break;
      @(negedge clk);
      if (grants >= 6) begin
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
      end else begin
        if (chg0) begin a0 = 32'($urandom_range(0, 15)) << 2; m0_addr = a0; chg0 = 1'b0; end
        if (chg1) begin a1 = 32'($urandom_range(0, 15)) << 2; m1_addr = a1; chg1 = 1'b0; end
      end
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    n_chk++; if (grants != 6 || q_p.size() != 0) $display("FAIL rr_done got=grants%0d pending%0d want=6/0", grants, q_p.size()); else n_pass++;
  endtask

  task automatic test_fixed_priority;
    int cnt0, rsp0, rsp1; logic bad1, got1; logic [31:0] d1;
    cnt0 = 0; rsp0 = 0; rsp1 = 0; bad1 = 1'b0; got1 = 1'b0; d1 = '0;
    repeat (4) @(negedge clk);
    drive(0, 32'h14, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    drive(1, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 80; cyc++) begin
      #1;
      if (fp_m0_rsp_valid) rsp0++;
      if (fp_m1_rsp_valid) begin rsp1++; d1 = fp_m1_rsp_data; end
      if (fp_m1_req_ready) begin if (cnt0 < 3) bad1 = 1'b1; got1 = 1'b1; end
      if (fp_m0_req_ready) cnt0++;
      if (rsp1 > 0) break;
      @(negedge clk);
      if (cnt0 >= 3) m0_req_valid = 1'b0;
      if (got1) m1_req_valid = 1'b0;
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    n_chk++; if (cnt0 != 3 || rsp0 != 3) $display("FAIL fp_port0 got=acc%0d rsp%0d want=3/3", cnt0, rsp0); else n_pass++;
    n_chk++; if (bad1 !== 1'b0) $display("FAIL fp_port1_early got=%b want=0", bad1); else n_pass++;
    n_chk++; if (got1 !== 1'b1 || rsp1 != 1) $display("FAIL fp_port1_served got=acc%b rsp%0d want=1/1", got1, rsp1); else n_pass++;
    n_chk++; if (d1 !== ref_load(32'h10, 2'd2, 1'b0)) $display("FAIL fp_port1_data got=%h want=%h", d1, ref_load(32'h10, 2'd2, 1'b0)); else n_pass++;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_errors;
    logic acc, re, oth; int lat, wrc; logic [31:0] rd, word;
    txn(1, 32'h12, 32'hAAAA5555, 1'b1, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if ({re, rd} !== {1'b1, 32'h0} || wrc != 0 || lat != 2) $display("FAIL err_word_st got=err%b data%h wr%0d lat%0d want=1/0/0/2", re, rd, wrc, lat); else n_pass++;
    txn(1, 32'h11, 32'h0, 1'b0, 2'd1, 1'b1, acc, lat, rd, re, wrc, oth);
    n_chk++; if ({re, rd} !== {1'b1, 32'h0}) $display("FAIL err_half_ld got=err%b data%h want=1/0", re, rd); else n_pass++;
    txn(1, 32'h10, 32'h12345678, 1'b1, 2'd3, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if ({re, rd} !== {1'b1, 32'h0} || wrc != 0 || oth) $display("FAIL err_size3 got=err%b data%h wr%0d oth%b want=1/0/0/0", re, rd, wrc, oth); else n_pass++;
    word = {dmem[8'h13], dmem[8'h12], dmem[8'h11], dmem[8'h10]};
    n_chk++; if (word !== ref_load(32'h10, 2'd2, 1'b0)) $display("FAIL err_mem_intact got=%h want=%h", word, ref_load(32'h10, 2'd2, 1'b0)); else n_pass++;
    txn(1, 32'h12, 32'h0, 1'b0, 2'd1, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if ({re, rd} !== {1'b0, ref_load(32'h12, 2'd1, 1'b0)}) $display("FAIL ok_half_ld got=err%b data%h want=0/%h", re, rd, ref_load(32'h12, 2'd1, 1'b0)); else n_pass++;
  endtask

  task automatic test_sign_ext;
    logic acc, re, oth; int lat, wrc; logic [31:0] rd;
    txn(0, 32'h3, 32'h00000080, 1'b1, 2'd0, 1'b0, acc, lat, rd, re, wrc, oth);
    ref_store(3, 32'h80, 2'd0);
    n_chk++; if (wrc != 1 || re !== 1'b0) $display("FAIL sx_byte_st got=wr%0d err%b want=1/0", wrc, re); else n_pass++;
    txn(0, 32'h3, 32'h0, 1'b0, 2'd0, 1'b1, acc, lat, rd, re, wrc, oth);
    n_chk++; if (rd !== 32'hFFFFFF80) $display("FAIL sx_signed got=%h want=ffffff80", rd); else n_pass++;
    txn(0, 32'h3, 32'h0, 1'b0, 2'd0, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if (rd !== 32'h00000080) $display("FAIL sx_zero got=%h want=00000080", rd); else n_pass++;
  endtask

  task automatic test_random;
    logic acc, re, oth, p, w, x, e; int lat, wrc; logic [31:0] rd, a, d, exp_d; logic [1:0] s;
    for (int i = 0; i < 24; i++) begin
      p = 1'($urandom_range(0, 1)); w = 1'($urandom_range(0, 1)); x = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3)); a = 32'h40 + 32'($urandom_range(0, 63)); d = $urandom;
      e = ref_err(a, s);
      exp_d = (!w && !e) ? ref_load(int'(a), s, x) : 32'h0;
      txn(p, a, d, w, s, x, acc, lat, rd, re, wrc, oth);
      if (w && !e) ref_store(int'(a), d, s);
      n_chk++;
      if (acc !== 1'b1 || lat != 2 || oth !== 1'b0)
        $display("FAIL rnd%0d_hs got=acc%b lat%0d oth%b want=1/2/0", i, acc, lat, oth);
      else n_pass++;
      n_chk++;
      if (re !== e || rd !== exp_d || wrc != ((w && !e) ? 1 : 0))
        $display("FAIL rnd%0d_rsp a=%h s=%0d w=%b got=err%b data%h wr%0d want=err%b data%h wr%0d", i, a, s, w, re, rd, wrc, e, exp_d, (w && !e) ? 1 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic acc, re, oth, seen; int lat, wrc; logic [31:0] rd;
    txn(0, 32'h20, 32'h11223344, 1'b1, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    ref_store(32'h20, 32'h11223344, 2'd2);
    @(negedge clk);
    drive(0, 32'h20, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 1'b1);
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (m0_req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    n_chk++; if (acc !== 1'b1) $display("FAIL rm_acc got=%b want=1", acc); else n_pass++;
    @(negedge clk);
    m0_req_valid = 1'b0;
    n_chk++; if (d_mem_wr_en !== 1'b1) $display("FAIL rm_access_wr got=%b want=1", d_mem_wr_en); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if (d_mem_wr_en !== 1'b0) $display("FAIL rm_wr_drop got=%b want=0", d_mem_wr_en); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      if (m0_rsp_valid || m1_rsp_valid) seen = 1'b1;
    end
    last_own = 1'b0;
    n_chk++; if (seen !== 1'b0) $display("FAIL rm_no_rsp got=%b want=0", seen); else n_pass++;
    n_chk++; if (m0_rsp_data !== 32'h0) $display("FAIL rm_rsp_cleared got=%h want=0", m0_rsp_data); else n_pass++;
    txn(0, 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, acc, lat, rd, re, wrc, oth);
    n_chk++; if (acc !== 1'b1 || lat != 2) $display("FAIL rm_idle got=acc%b lat%0d want=1/2", acc, lat); else n_pass++;
    n_chk++; if (rd !== ref_load(32'h20, 2'd2, 1'b0)) $display("FAIL rm_old_data got=%h want=%h", rd, ref_load(32'h20, 2'd2, 1'b0)); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin dmem[i] = 8'h0; ref_mem[i] = 8'h0; end
    mem_gen = 1;
    drive(0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    test_reset;
    test_store_load;
    test_round_robin;
    test_fixed_priority;
    test_errors;
    test_sign_ext;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/d_mem_arbiter.md
Name: d_mem_arbiter

Overview:
- Shares the single data memory (d_mem) between two requesters: port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Accepts one request at a time through a valid/ready handshake and sequences it onto the d_mem signal set.
- Returns a one-cycle response to the owning port.
- Flags misaligned or illegal-size accesses without touching memory.
- Sits between the requesters and d_mem; d_mem is its only downstream.

Parameters:
- BUS_WIDTH, 32, width of address and data buses.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 highest.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req_valid  in  1  request valid, port N (N=0,1)
- mN_req_ready  out  1  request accepted this cycle, port N
- mN_addr  in  BUS_WIDTH  byte address, port N
- mN_wr_data  in  BUS_WIDTH  store data, port N
- mN_wr_en  in  1  1 = store, 0 = load, port N
- mN_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- mN_sz_ex  in  1  load extension: 0 zero, 1 sign
- mN_rsp_valid  out  1  response pulse, port N
- mN_rsp_data  out  BUS_WIDTH  load data; 0 for stores and errors
- mN_rsp_err  out  1  misaligned or illegal size, valid with rsp_valid
- d_mem_address  out  BUS_WIDTH  to d_mem
- d_mem_wr_data  out  BUS_WIDTH  to d_mem
- d_mem_wr_en  out  1  to d_mem
- d_mem_size  out  2  to d_mem
- d_mem_sz_ex  out  1  to d_mem
- d_mem_rd_data  in  BUS_WIDTH  from d_mem; combinational read of d_mem_address

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values:
  - state IDLE; rr pointer = port 0.
  - All latched request registers, d_mem_* outputs, rsp_data, rsp_err and rsp_valid are 0.
  - Both req_ready are 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Grant is computed combinationally from the valids.
  - RR_EN=1: with both valid, the port not granted last wins; with one valid, that port wins.
  - RR_EN=0: port 0 always wins when valid.
  - req_ready=1 only to the granted port, and only in IDLE; ready never asserts in IDLE without the matching valid.
  - On valid && ready: latch addr, wr_data, wr_en, size, sz_ex and the owner id; evaluate alignment; go to ACCESS.
  - No valid: stay in IDLE.
- Alignment error (err=1) when any of:
  - size=11
  - size=01 with addr[0]=1
  - size=10 with addr[1:0]≠00
- ACCESS (exactly 1 cycle):
  - d_mem_address, d_mem_wr_data, d_mem_size and d_mem_sz_ex come from the latched registers. They hold their last values in all other states.
  - d_mem_wr_en = latched wr_en && !err && state==ACCESS, decoded from state so it is never high outside ACCESS.
  - At the ACCESS→RESP edge: rsp_data ← (load && !err) ? d_mem_rd_data : 0, and rsp_err ← err.
  - Update the rr pointer to the owner.
- RESP (exactly 1 cycle):
  - rsp_valid=1 to the owner only; the other port's rsp_valid stays 0.
  - No response backpressure. Return to IDLE.
- rsp_data and rsp_err hold their values after the pulse, until the next RESP.
- Latency: accept at edge T → memory access during cycle T+1 → rsp_valid during cycle T+2. Maximum throughput is one transaction per 3 cycles.
- Requester rules:
  - Fields must stay stable while valid && !ready.
  - Dropping valid before acceptance is legal and is not an error.
  - A valid asserted while the arbiter is busy waits in the requester.
- Simultaneous events:
  - A request accepted in IDLE and a valid on the other port in the same cycle: the other port waits.
  - Under RR_EN=1 with both requesters continuously valid, grants alternate strictly, so neither port starves.
- Reset mid-operation:
  - The in-flight transaction is dropped and no rsp_valid is issued.
  - d_mem_wr_en falls to 0 immediately (asynchronous), so a store whose ACCESS cycle is cut by rst is not committed.

Test Plan:
1. Port 0 word store addr=0x10 data=0xDEADBEEF, then word load addr=0x10 → d_mem_wr_en high exactly one cycle; load rsp_valid 2 cycles after accept, rsp_data=0xDEADBEEF, rsp_err=0.
2. RR_EN=1, both ports continuously valid with loads for 6 transactions → grants alternate 0,1,0,1,0,1; each rsp_valid reaches only its own port.
3. RR_EN=0, both ports continuously valid → port 0 granted every time; port 1 accepted only after port 0 drops valid.
4. Port 1 word store addr=0x12, half load addr=0x11, and size=11 → d_mem_wr_en stays 0; rsp_err=1, rsp_data=0; memory at 0x10 unchanged.
5. Byte load of 0x80 at addr=0x3 with sz_ex=1 → rsp_data=0xFFFFFF80; with sz_ex=0 → rsp_data=0x00000080.
6. Assert rst during the ACCESS cycle of a store to 0x20 → no rsp_valid; state returns to IDLE; a later load of 0x20 returns the old contents.
